// File: rtl/jvm_mem_ctrl.sv
// jvm_mem_ctrl: byte-wide data memory for the JVM core.
// Serves 1/2/4-byte big-endian accesses, one byte per cycle, behind a
// start/ready handshake. Optional wait states, bounds/size error reporting,
// and a zero-fill sweep of the whole array after every reset.
module jvm_mem_ctrl #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int WAIT   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rwn,
    input  logic [1:0]        size,
    input  logic              sign,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              ready,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_WAIT,
        ST_XFER,
        ST_DONE
    } state_t;

    // One bit wider than the address so the last byte of a request can be
    // checked against DEPTH without wrapping.
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    state_t            state, next_state;
    logic [ADDR_W-1:0] ptr;        // clear pointer, then current transfer byte
    logic              rwn_q;
    logic              sign_q;
    logic [1:0]        size_q;
    logic              err_q;      // accepted request was rejected
    logic [3:0]        cnt_q;      // wait states remaining
    logic [2:0]        rem_q;      // bytes remaining
    logic [31:0]       wdata_q;    // write data, left-justified, MSB first
    logic [23:0]       shift_q;    // read bytes gathered so far

    logic [7:0]        mem [DEPTH];

    logic [2:0]        req_n;
    logic [ADDR_W:0]   last_addr;
    logic              req_err;
    logic [31:0]       req_wdata;
    logic [7:0]        rd_byte;
    logic [31:0]       assembled;
    logic [31:0]       extended;
    logic              mem_we;
    logic [7:0]        mem_wd;

    // Decode the incoming request: byte count, bounds check, data alignment.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        req_n     = 3'd4;
        req_wdata = data_in;
        case (size)
            2'b00: begin
                req_n     = 3'd1;
                req_wdata = {data_in[7:0], 24'h0};
            end
            2'b01: begin
                req_n     = 3'd2;
                req_wdata = {data_in[15:0], 16'h0};
            end
            default: begin
                req_n     = 3'd4;
                req_wdata = data_in;
            end
        endcase
        last_addr = {1'b0, address} + (ADDR_W+1)'(req_n) - (ADDR_W+1)'(1);
        req_err   = (size == 2'b11) || (last_addr >= DEPTH_W);
    end

    // Read-side assembly and sign/zero extension of the finished value.
    always_comb begin
        rd_byte   = mem[ptr];
        assembled = {shift_q, rd_byte};
        extended  = assembled;
        case (size_q)
            2'b00:   extended = sign_q ? {{24{assembled[7]}}, assembled[7:0]}
                                       : {24'h0, assembled[7:0]};
            2'b01:   extended = sign_q ? {{16{assembled[15]}}, assembled[15:0]}
                                       : {16'h0, assembled[15:0]};
            default: extended = assembled;
        endcase
        // A reset edge aborts the transfer, so it must not land a byte.
        mem_we = !reset && ((state == ST_CLEAR) ||
                            (state == ST_XFER && !err_q && !rwn_q));
        mem_wd = (state == ST_CLEAR) ? 8'h00 : wdata_q[31:24];
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register sees the pre-edge value of every other register.
        if (reset) state <= ST_CLEAR;
        else       state <= next_state;
    end

    // Next-state and handshake outputs.
    always_comb begin
        next_state = state;
        ready      = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            ST_CLEAR: if (ptr == ADDR_W'(DEPTH-1)) next_state = ST_IDLE;
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    // Rejected requests skip the wait states and spend one
                    // idle cycle in XFER, giving a fixed error latency.
                    if (req_err)       next_state = ST_XFER;
                    else if (WAIT > 0) next_state = ST_WAIT;
                    else               next_state = ST_XFER;
                end
            end
            ST_WAIT: if (cnt_q == 4'd1) next_state = ST_XFER;
            ST_XFER: if (err_q || rem_q == 3'd1) next_state = ST_DONE;
            ST_DONE: begin
                done       = 1'b1;
                error      = err_q;
                next_state = ST_IDLE;
            end
            default: next_state = ST_CLEAR;
        endcase
    end

    // Datapath: request capture, pointer, counters, read result.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= '0;
            data_out <= '0;
            err_q    <= 1'b0;
            rwn_q    <= 1'b1;
            sign_q   <= 1'b0;
            size_q   <= 2'b00;
            cnt_q    <= '0;
            rem_q    <= '0;
            wdata_q  <= '0;
            shift_q  <= '0;
        end else begin
            case (state)
                ST_CLEAR: ptr <= ptr + 1'b1;
                ST_IDLE: if (start) begin
                    rwn_q   <= rwn;
                    sign_q  <= sign;
                    size_q  <= size;
                    err_q   <= req_err;
                    ptr     <= address;
                    cnt_q   <= 4'(WAIT);
                    rem_q   <= req_n;
                    wdata_q <= req_wdata;
                    shift_q <= '0;
                end
                ST_WAIT: cnt_q <= cnt_q - 1'b1;
                ST_XFER: if (!err_q) begin
                    ptr     <= ptr + 1'b1;
                    rem_q   <= rem_q - 1'b1;
                    wdata_q <= {wdata_q[23:0], 8'h00};
                    shift_q <= assembled[23:0];
                    if (rem_q == 3'd1 && rwn_q) data_out <= extended;
                end
                default: ;
            endcase
        end
    end

    // Byte array: one write port shared by the clear sweep and writes.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset branch; the CLEAR sweep zeroes it,
        // which keeps it mappable onto plain RAM.
        if (mem_we) mem[ptr] <= mem_wd;
    end

endmodule

// File: tb/tb_jvm_mem_ctrl.sv
// Directed self-checking bench for jvm_mem_ctrl: one instance with no wait
// states, one with WAIT=3, sharing clock, reset and request fields.
module tb_jvm_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        start_w = 1'b0;
    logic        rwn = 1'b1;
    logic [1:0]  size = 2'b00;
    logic        sign = 1'b0;
    logic [7:0]  address = 8'h00;
    logic [31:0] data_in = 32'h0;
    logic [31:0] data_out, data_out_w;
    logic        ready, done, error;
    logic        ready_w, done_w, error_w;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jvm_mem_ctrl #(.DEPTH(256), .ADDR_W(8), .WAIT(0)) dut (
        .clk(clk), .reset(reset), .start(start), .rwn(rwn), .size(size),
        .sign(sign), .address(address), .data_in(data_in),
        .data_out(data_out), .ready(ready), .done(done), .error(error)
    );

    jvm_mem_ctrl #(.DEPTH(256), .ADDR_W(8), .WAIT(3)) dut_w (
        .clk(clk), .reset(reset), .start(start_w), .rwn(rwn), .size(size),
        .sign(sign), .address(address), .data_in(data_in),
        .data_out(data_out_w), .ready(ready_w), .done(done_w), .error(error_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Pulse reset for one edge and time the clear sweep to ready.
    task automatic do_reset(input string tag);
        int c;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check({tag, "_ready0"}, 32'(ready), 32'd0);
        check({tag, "_done0"},  32'(done),  32'd0);
        check({tag, "_dout0"},  data_out,   32'h0);
        c = 0;
        while (!ready && c < 1000) begin
            @(posedge clk); #1;
            c++;
            if (done || done_w) check({tag, "_spurious_done"}, 32'd1, 32'd0);
        end
        check({tag, "_clear_cycles"}, 32'(c), 32'd256);
        check({tag, "_ready_w"}, 32'(ready_w), 32'd1);
    endtask

    // Issue one request on either instance and check latency, result, error,
    // and that ready returns one cycle after done.
    task automatic run(input string tag, input bit w, input bit rd,
                       input logic [1:0] sz, input bit sg, input logic [7:0] a,
                       input logic [31:0] d, input int exp_lat,
                       input logic [31:0] exp_q, input bit exp_e);
        int n;
        int lat;
        logic [31:0] q;
        logic e;
        n = 0;
        while (!(w ? ready_w : ready) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_idle"}, 32'(w ? ready_w : ready), 32'd1);
        rwn = rd; size = sz; sign = sg; address = a; data_in = d;
        if (w) start_w = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start_w = 1'b0;
        lat = -1; q = 'x; e = 1'bx;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (w ? done_w : done) begin
                lat = c;
                q   = w ? data_out_w : data_out;
                e   = w ? error_w : error;
                break;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, q, exp_q);
        check({tag, "_err"}, 32'(e), 32'(exp_e));
        @(posedge clk); #1;
        check({tag, "_ready_after"}, 32'(w ? ready_w : ready), 32'd1);
    endtask

    initial begin
        int d1, d2, nd, lat;

        do_reset("rst");
        run("rd_w00", 0, 1, 2'b10, 0, 8'h00, 32'h0, 4, 32'h00000000, 0);

        run("wr_w10", 0, 0, 2'b10, 0, 8'h10, 32'h80A1B2C3, 4, 32'h00000000, 0);
        run("rd_b10", 0, 1, 2'b00, 0, 8'h10, 32'h0, 1, 32'h00000080, 0);
        run("rd_b11", 0, 1, 2'b00, 0, 8'h11, 32'h0, 1, 32'h000000A1, 0);
        run("rd_b12", 0, 1, 2'b00, 0, 8'h12, 32'h0, 1, 32'h000000B2, 0);
        run("rd_b13", 0, 1, 2'b00, 0, 8'h13, 32'h0, 1, 32'h000000C3, 0);
        run("rd_w10", 0, 1, 2'b10, 0, 8'h10, 32'h0, 4, 32'h80A1B2C3, 0);
        run("rd_h10s", 0, 1, 2'b01, 1, 8'h10, 32'h0, 2, 32'hFFFF80A1, 0);
        run("rd_h10z", 0, 1, 2'b01, 0, 8'h10, 32'h0, 2, 32'h000080A1, 0);
        run("rd_b11s", 0, 1, 2'b00, 1, 8'h11, 32'h0, 1, 32'hFFFFFFA1, 0);
        run("rd_h12s", 0, 1, 2'b01, 1, 8'h12, 32'h0, 2, 32'hFFFFB2C3, 0);
        run("rd_h11z", 0, 1, 2'b01, 0, 8'h11, 32'h0, 2, 32'h0000A1B2, 0);

        // Back-to-back byte reads with start held: done at 1 and 4.
        rwn = 1; size = 2'b00; sign = 0; address = 8'h10; start = 1'b1;
        @(posedge clk); #1;
        d1 = -1; d2 = -1; nd = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (done) begin
                nd++;
                if (nd == 1) d1 = c; else if (nd == 2) d2 = c;
            end
            if (c == 4) start = 1'b0;
        end
        check("b2b_first", 32'(d1), 32'd1);
        check("b2b_second", 32'(d2), 32'd4);
        check("b2b_count", 32'(nd), 32'd2);
        check("b2b_data", data_out, 32'h00000080);

        // start held during a busy word write must not launch a byte write.
        rwn = 0; size = 2'b10; address = 8'h20; data_in = 32'h11223344; start = 1'b1;
        @(posedge clk); #1;
        size = 2'b00; address = 8'h30; data_in = 32'h55;
        lat = -1; nd = 0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (done) begin nd++; lat = c; end
            if (c == 2) start = 1'b0;
        end
        check("busy_lat", 32'(lat), 32'd4);
        check("busy_done_count", 32'(nd), 32'd1);
        check("busy_dout", data_out, 32'h00000080);
        run("rd_b30", 0, 1, 2'b00, 0, 8'h30, 32'h0, 1, 32'h00000000, 0);
        run("rd_w20", 0, 1, 2'b10, 0, 8'h20, 32'h0, 4, 32'h11223344, 0);

        // Bounds and size errors: one-cycle latency, data_out untouched.
        run("err_wFD", 0, 0, 2'b10, 0, 8'hFD, 32'hDEADBEEF, 1, 32'h11223344, 1);
        run("err_sz3", 0, 1, 2'b11, 0, 8'h00, 32'h0, 1, 32'h11223344, 1);
        run("err_hFF", 0, 1, 2'b01, 1, 8'hFF, 32'h0, 1, 32'h11223344, 1);
        run("rd_wFC", 0, 1, 2'b10, 0, 8'hFC, 32'h0, 4, 32'h00000000, 0);
        run("wr_bFF", 0, 0, 2'b00, 0, 8'hFF, 32'h0000005A, 1, 32'h00000000, 0);
        run("rd_bFF", 0, 1, 2'b00, 0, 8'hFF, 32'h0, 1, 32'h0000005A, 0);

        // Wait-state instance.
        run("w3_wr_b05", 1, 0, 2'b00, 0, 8'h05, 32'h0000007E, 4, 32'h00000000, 0);
        run("w3_rd_w04", 1, 1, 2'b10, 0, 8'h04, 32'h0, 7, 32'h007E0000, 0);
        run("w3_err_wFE", 1, 1, 2'b10, 0, 8'hFE, 32'h0, 1, 32'h007E0000, 1);

        // Reset in the middle of a word write: no done, array re-cleared.
        rwn = 0; size = 2'b10; address = 8'h40; data_in = 32'hCAFEF00D; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nd = 0;
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        check("abort_no_done_pre", 32'(nd), 32'd0);
        do_reset("rst_abort");
        for (int a = 0; a < 256; a += 4) begin
            run($sformatf("clr_w%02h", a), 0, 1, 2'b10, 0, 8'(a), 32'h0, 4, 32'h0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard stop in case something stalls beyond every bounded wait.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
